// File: rtl/pe_ingress_dispatch.sv
// PE ingress dispatcher: routes config/const/data packets to the PAT, the register file and the FU issue register.
// Optional dropped-packet counter is enabled by defining PE_DROP_CNT_EN.
module pe_ingress_dispatch #(
    parameter logic [1:0] X_COORD   = 2'd0,
    parameter logic [1:0] Y_COORD   = 2'd0,
    parameter logic [3:0] CONF_PID  = 4'hF,
    parameter logic [3:0] CONST_PID = 4'hE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [35:0] in_pkt,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        iss_valid,
    input  logic        iss_ready,
    output logic [22:0] iss_entry,
    output logic [31:0] iss_data,
    output logic [3:0]  iss_pid,
    output logic        pat_miss,
    output logic [7:0]  drop_cnt
);

    // Payload layouts: config = {x[31:30], y[29:28], pat_ind[27:24], rsvd[23], entry[22:0]}
    //                  const  = {x[31:30], y[29:28], rd[27:23], imm[22:0]}
    logic [3:0]  pktPid;
    logic [31:0] pktPayload;
    logic        accept;
    logic        isConf;
    logic        isConst;
    logic        isData;
    logic        coordMatch;
    logic        cfgWrite;
    logic        constWrite;
    logic        dataHit;
    logic        dataMiss;

    logic [22:0] pat_q [16];
    logic [15:0] patValid_q;

    logic        issValid_q, issValid_d;
    logic [22:0] issEntry_q, issEntry_d;
    logic [31:0] issData_q,  issData_d;
    logic [3:0]  issPid_q,   issPid_d;

    logic        rfWe_q;
    logic [4:0]  rfWaddr_q;
    logic [31:0] rfWdata_q;
    logic        patMiss_q;

    assign pktPid     = in_pkt[35:32];
    assign pktPayload = in_pkt[31:0];
    assign in_ready   = !issValid_q || iss_ready;
    assign accept     = in_valid && in_ready;

    assign isConf     = (pktPid == CONF_PID);
    assign isConst    = (pktPid == CONST_PID);
    assign isData     = !isConf && !isConst;
    assign coordMatch = (pktPayload[31:30] == X_COORD) && (pktPayload[29:28] == Y_COORD);

    assign cfgWrite   = accept && isConf && coordMatch;
    assign constWrite = accept && isConst && coordMatch;
    assign dataHit    = accept && isData && patValid_q[pktPid];
    assign dataMiss   = accept && isData && !patValid_q[pktPid];

    // A new hit reloads the issue register even while the old one is being accepted.
    always_comb begin
        issValid_d = issValid_q;
        issEntry_d = issEntry_q;
        issData_d  = issData_q;
        issPid_d   = issPid_q;
        if (dataHit) begin
            issValid_d = 1'b1;
            issEntry_d = pat_q[pktPid];
            issData_d  = pktPayload;
            issPid_d   = pktPid;
        end else if (iss_ready) begin
            issValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                pat_q[i] <= '0;
            end
            patValid_q <= '0;
        end else if (cfgWrite) begin
            pat_q[pktPayload[27:24]]      <= pktPayload[22:0];
            patValid_q[pktPayload[27:24]] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issValid_q <= 1'b0;
            issEntry_q <= '0;
            issData_q  <= '0;
            issPid_q   <= '0;
            rfWe_q     <= 1'b0;
            rfWaddr_q  <= '0;
            rfWdata_q  <= '0;
            patMiss_q  <= 1'b0;
        end else begin
            issValid_q <= issValid_d;
            issEntry_q <= issEntry_d;
            issData_q  <= issData_d;
            issPid_q   <= issPid_d;
            rfWe_q     <= constWrite;
            patMiss_q  <= dataMiss;
            if (constWrite) begin
                rfWaddr_q <= pktPayload[27:23];
                rfWdata_q <= {9'b0, pktPayload[22:0]};
            end
        end
    end

    assign iss_valid = issValid_q;
    assign iss_entry = issEntry_q;
    assign iss_data  = issData_q;
    assign iss_pid   = issPid_q;
    assign rf_we     = rfWe_q;
    assign rf_waddr  = rfWaddr_q;
    assign rf_wdata  = rfWdata_q;
    assign pat_miss  = patMiss_q;

`ifdef PE_DROP_CNT_EN
    logic       dropEvt;
    logic [7:0] dropCnt_q;

    assign dropEvt = dataMiss || (accept && (isConf || isConst) && !coordMatch);

    // Saturating so a flood of stray packets never wraps back to a small count.
    always_ff @(posedge clk) begin
        if (rst) begin
            dropCnt_q <= '0;
        end else if (dropEvt && (dropCnt_q != 8'hFF)) begin
            dropCnt_q <= dropCnt_q + 8'd1;
        end
    end

    assign drop_cnt = dropCnt_q;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pe_ingress_dispatch.sv
// Directed, table-driven bench for pe_ingress_dispatch plus hand sequences for back-pressure, reprogramming, reset and drop saturation.
// Expected drop counts follow PE_DROP_CNT_EN.
module tb_pe_ingress_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [35:0] inPkt;
    logic        rfWe;
    logic [4:0]  rfWaddr;
    logic [31:0] rfWdata;
    logic        issValid;
    logic        issReady;
    logic [22:0] issEntry;
    logic [31:0] issData;
    logic [3:0]  issPid;
    logic        patMiss;
    logic [7:0]  dropCnt;

    int errors = 0;
    int checks = 0;

`ifdef PE_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic        valid;
        logic [35:0] pkt;
        logic        ready;
        logic        expInReady;
        logic        expIssValid;
        logic [22:0] expEntry;
        logic [31:0] expData;
        logic [3:0]  expPid;
        logic        expRfWe;
        logic [4:0]  expRfAddr;
        logic [31:0] expRfData;
        logic        expMiss;
    } vec_t;

    vec_t vecs [10];

    pe_ingress_dispatch dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_pkt    (inPkt),
        .rf_we     (rfWe),
        .rf_waddr  (rfWaddr),
        .rf_wdata  (rfWdata),
        .iss_valid (issValid),
        .iss_ready (issReady),
        .iss_entry (issEntry),
        .iss_data  (issData),
        .iss_pid   (issPid),
        .pat_miss  (patMiss),
        .drop_cnt  (dropCnt)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [35:0] p, input logic r);
        inValid  = v;
        inPkt    = p;
        issReady = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the whole sequence: reset, vector table, then the multi-cycle corner cases.
    initial begin
        vecs[0] = '{1'b0, 36'h0,           1'b1, 1'b1, 1'b0, 23'h0,     32'h0,        4'h0, 1'b0, 5'd0, 32'h0,        1'b0};
        vecs[1] = '{1'b1, {4'hF, 32'h03012345}, 1'b1, 1'b1, 1'b0, 23'h0, 32'h0,       4'h0, 1'b0, 5'd0, 32'h0,        1'b0};
        vecs[2] = '{1'b1, {4'h3, 32'hDEADBEEF}, 1'b1, 1'b1, 1'b1, 23'h12345, 32'hDEADBEEF, 4'h3, 1'b0, 5'd0, 32'h0,    1'b0};
        vecs[3] = '{1'b1, {4'hE, 32'h03FFFFFF}, 1'b1, 1'b1, 1'b0, 23'h12345, 32'hDEADBEEF, 4'h3, 1'b1, 5'd7, 32'h007FFFFF, 1'b0};
        vecs[4] = '{1'b0, 36'h0,           1'b1, 1'b1, 1'b0, 23'h12345, 32'hDEADBEEF, 4'h3, 1'b0, 5'd7, 32'h007FFFFF, 1'b0};
        vecs[5] = '{1'b1, {4'h5, 32'h0},   1'b1, 1'b1, 1'b0, 23'h12345, 32'hDEADBEEF, 4'h3, 1'b0, 5'd7, 32'h007FFFFF, 1'b1};
        vecs[6] = '{1'b0, 36'h0,           1'b1, 1'b1, 1'b0, 23'h12345, 32'hDEADBEEF, 4'h3, 1'b0, 5'd7, 32'h007FFFFF, 1'b0};
        vecs[7] = '{1'b1, {4'hF, 32'h46000055}, 1'b1, 1'b1, 1'b0, 23'h12345, 32'hDEADBEEF, 4'h3, 1'b0, 5'd7, 32'h007FFFFF, 1'b0};
        vecs[8] = '{1'b1, {4'h6, 32'h00000001}, 1'b1, 1'b1, 1'b0, 23'h12345, 32'hDEADBEEF, 4'h3, 1'b0, 5'd7, 32'h007FFFFF, 1'b1};
        vecs[9] = '{1'b1, {4'hE, 32'h14800005}, 1'b1, 1'b1, 1'b0, 23'h12345, 32'hDEADBEEF, 4'h3, 1'b0, 5'd7, 32'h007FFFFF, 1'b0};

        rst = 1'b1;
        applyStimulus(1'b0, 36'h0, 1'b1);
        tick();
        tick();
        checkOutput("rst.issValid", 64'(issValid), 64'd0);
        checkOutput("rst.rfWe",     64'(rfWe),     64'd0);
        checkOutput("rst.patMiss",  64'(patMiss),  64'd0);
        checkOutput("rst.dropCnt",  64'(dropCnt),  64'd0);
        checkOutput("rst.issEntry", 64'(issEntry), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].pkt, vecs[i].ready);
            checkOutput($sformatf("v%0d.inReady", i), 64'(inReady), 64'(vecs[i].expInReady));
            tick();
            checkOutput($sformatf("v%0d.issValid", i), 64'(issValid), 64'(vecs[i].expIssValid));
            checkOutput($sformatf("v%0d.issEntry", i), 64'(issEntry), 64'(vecs[i].expEntry));
            checkOutput($sformatf("v%0d.issData", i),  64'(issData),  64'(vecs[i].expData));
            checkOutput($sformatf("v%0d.issPid", i),   64'(issPid),   64'(vecs[i].expPid));
            checkOutput($sformatf("v%0d.rfWe", i),     64'(rfWe),     64'(vecs[i].expRfWe));
            checkOutput($sformatf("v%0d.rfWaddr", i),  64'(rfWaddr),  64'(vecs[i].expRfAddr));
            checkOutput($sformatf("v%0d.rfWdata", i),  64'(rfWdata),  64'(vecs[i].expRfData));
            checkOutput($sformatf("v%0d.patMiss", i),  64'(patMiss),  64'(vecs[i].expMiss));
        end
        applyStimulus(1'b0, 36'h0, 1'b1);
        checkOutput("tbl.dropCnt", 64'(dropCnt), CNT_EN ? 64'd4 : 64'd0);

        // Back-pressure: second packet waits, then both issue on consecutive cycles.
        applyStimulus(1'b1, {4'h3, 32'hA1A1A1A1}, 1'b0);
        checkOutput("bp.inReady0", 64'(inReady), 64'd1);
        tick();
        checkOutput("bp.issValid0", 64'(issValid), 64'd1);
        checkOutput("bp.issData0",  64'(issData),  64'hA1A1A1A1);
        applyStimulus(1'b1, {4'h3, 32'hA2A2A2A2}, 1'b0);
        checkOutput("bp.inReadyHeld", 64'(inReady), 64'd0);
        tick();
        tick();
        checkOutput("bp.issValidHeld", 64'(issValid), 64'd1);
        checkOutput("bp.issDataHeld",  64'(issData),  64'hA1A1A1A1);
        checkOutput("bp.issPidHeld",   64'(issPid),   64'h3);
        applyStimulus(1'b1, {4'h3, 32'hA2A2A2A2}, 1'b1);
        checkOutput("bp.inReadyRel", 64'(inReady), 64'd1);
        tick();
        checkOutput("bp.issValid1", 64'(issValid), 64'd1);
        checkOutput("bp.issData1",  64'(issData),  64'hA2A2A2A2);
        applyStimulus(1'b0, 36'h0, 1'b1);
        tick();
        checkOutput("bp.issValidDone", 64'(issValid), 64'd0);

        // Reprogramming PAT[3] leaves the captured entry alone; the next lookup sees the new one.
        applyStimulus(1'b1, {4'h3, 32'hB0B0B0B0}, 1'b1);
        tick();
        checkOutput("rp.issEntryOld", 64'(issEntry), 64'h12345);
        applyStimulus(1'b1, {4'hF, 32'h03000777}, 1'b1);
        checkOutput("rp.issEntryPre", 64'(issEntry), 64'h12345);
        tick();
        checkOutput("rp.issValidCfg", 64'(issValid), 64'd0);
        checkOutput("rp.issEntryKept", 64'(issEntry), 64'h12345);
        applyStimulus(1'b1, {4'h3, 32'hB1B1B1B1}, 1'b1);
        tick();
        checkOutput("rp.issValidNew", 64'(issValid), 64'd1);
        checkOutput("rp.issEntryNew", 64'(issEntry), 64'h00777);
        checkOutput("rp.issDataNew",  64'(issData),  64'hB1B1B1B1);

        // Reset with an issue pending.
        applyStimulus(1'b1, {4'h3, 32'hC0C0C0C0}, 1'b0);
        tick();
        checkOutput("mr.issValidPend", 64'(issValid), 64'd1);
        rst = 1'b1;
        applyStimulus(1'b0, 36'h0, 1'b0);
        tick();
        rst = 1'b0;
        checkOutput("mr.issValid", 64'(issValid), 64'd0);
        checkOutput("mr.inReady0", 64'(inReady),  64'd1);
        tick();
        checkOutput("mr.inReady1", 64'(inReady),  64'd1);
        applyStimulus(1'b1, {4'h3, 32'hC1C1C1C1}, 1'b1);
        tick();
        checkOutput("mr.patMiss",  64'(patMiss),  64'd1);
        checkOutput("mr.issValidMiss", 64'(issValid), 64'd0);
        checkOutput("mr.dropCnt",  64'(dropCnt),  CNT_EN ? 64'd1 : 64'd0);
        applyStimulus(1'b0, 36'h0, 1'b1);
        tick();
        checkOutput("mr.patMissPulse", 64'(patMiss), 64'd0);

        // Flood of mis-addressed config packets saturates the drop counter.
        applyStimulus(1'b1, {4'hF, 32'h46000055}, 1'b1);
        repeat (300) tick();
        applyStimulus(1'b0, 36'h0, 1'b1);
        tick();
        checkOutput("sat.dropCnt", 64'(dropCnt), CNT_EN ? 64'hFF : 64'd0);
        applyStimulus(1'b1, {4'h6, 32'h00000002}, 1'b1);
        tick();
        checkOutput("sat.patMiss6", 64'(patMiss), 64'd1);
        checkOutput("sat.dropCntHold", 64'(dropCnt), CNT_EN ? 64'hFF : 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
